rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Write-side front end for the processor's 32×32 register file. It merges two result producers into the file's single write port (A3/WD3/WE3): an ALU channel with priority and no buffering, and a load channel buffered in a small FIFO. It discards writes to x0, preserves write-after-write order per destination register, and exports a pending-write mask for the hazard logic. It sits between the execute/memory stages and the register file.

## Interface
- DEPTH, 4, load FIFO entries; power of two, ≥2
- XLEN, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result offered
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this edge when alu_valid && alu_ready
- ld_valid  in  1  load result offered
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load data
- ld_ready  out  1  load result accepted this edge when ld_valid && ld_ready
- A3  out  5  register-file write address (registered)
- WD3  out  XLEN  register-file write data (registered)
- WE3  out  1  register-file write enable (registered)
- pending  out  32  bit r set while any queued load targets register r
- busy  out  1  count≠0 or WE3 high

## Operation
- Load FIFO: DEPTH entries of {rd, data}, wrap-around read/write pointers, count 0..DEPTH.
- ld_ready = (count < DEPTH). A push is never allowed when full, even if a pop happens in the same cycle.
- A load with ld_rd = 0 is accepted (handshake completes) and dropped: no push, no write.
- ALU: alu_ready = !(count == DEPTH) && !(alu_rd ≠ 0 && pending[alu_rd]).
  - The ALU stalls on a full FIFO so that loads cannot starve.
  - The ALU stalls on a WAW hit so that an older load cannot overwrite a younger ALU result.
- alu_ready is combinational from alu_rd, pending, and count. It is independent of alu_valid.
- Write selection each edge, in priority order:
  1. An accepted ALU result with alu_rd ≠ 0 drives the output register.
  2. Otherwise, if count > 0, the FIFO head is popped and drives the output register.
  3. Otherwise WE3 ← 0.
- An accepted ALU result with alu_rd = 0 consumes no port slot. The FIFO head may pop in that same cycle.
- When WE3 ← 0, A3 and WD3 hold their previous values.
- pending is the OR of one-hot(rd) over all valid FIFO entries. Bit 0 is always 0. It updates on the same edge as push and pop.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Reset (asynchronous, any time, including mid-drain):
  - count = 0, pointers = 0, WE3 = 0, A3 = 0, WD3 = 0, pending = 0.
  - Queued loads are discarded.
  - ld_ready = 1 and alu_ready = 1 while in reset and after it.

## Timing
- ALU path: accepted at edge N → WE3 = 1 with A3/WD3 during cycle N..N+1 → register file written at edge N+1.
- Load path, FIFO empty and no ALU traffic: pushed at edge N → popped at edge N+1 → file written at edge N+2. No same-cycle bypass through the FIFO.
- Load path with continuous ALU traffic: the head waits until a cycle with no accepted nonzero-rd ALU result. Once the FIFO fills, alu_ready drops, so the wait is bounded.
- WE3 stays high for exactly one cycle per write. Back-to-back writes produce WE3 high on consecutive cycles.
- Throughput: one register write per cycle.

## Test plan
- Reset then idle: WE3 = 0, A3 = 0, WD3 = 0, pending = 0, ld_ready = 1, alu_ready = 1, busy = 0.
- ALU write rd=5, data=0x0000_0006 at edge N → WE3 = 1, A3 = 5, WD3 = 6 after N; WE3 = 0 after N+1 with no new traffic.
- Loads to rd 9, 11, 12 on three consecutive edges with no ALU traffic:
  - Writes appear in order 9, 11, 12, each two edges after its push.
  - pending bits 9, 11, 12 set, then clear as each entry pops.
- Fill FIFO (DEPTH = 4) while ALU is continuously valid to distinct registers:
  - ld_ready = 0 at count 4.
  - alu_ready = 0 at count 4; one load pops and ld_ready returns to 1.
- WAW: queue a load to rd 6, then offer ALU rd=6, data=0xA:
  - alu_ready = 0 until the load writes.
  - Write order on the port is load then 0xA.
- Writes to x0 from both channels: handshakes complete, WE3 never asserts, pending[0] = 0. Assert rst mid-drain with count = 3 → count = 0 and WE3 = 0 immediately, and no queued write ever appears afterward.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Merges a priority ALU result stream and a FIFO-buffered load stream onto the register-file write port.
// One registered write per cycle; ALU stalls on a full FIFO or a pending-load WAW hit, loads stall only when full.
module rf_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic [4:0]      A3,
  output logic [XLEN-1:0] WD3,
  output logic            WE3,
  output logic [31:0]     pending,
  output logic            busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [4:0]      a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            we3_q, we3_d;

  logic [31:0]     pending_c;
  logic [PW-1:0]   scan_idx;
  logic            full;
  logic            alu_wr;
  logic            push;
  logic            pop;

  // Scan live entries starting at the head so pending tracks exactly what is queued.
  always_comb begin
    pending_c = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        pending_c[rd_mem_q[scan_idx]] = 1'b1;
      end
    end
    pending_c[0] = 1'b0;
  end

  assign full      = (count_q == FULL);
  assign ld_ready  = !full;
  assign alu_ready = !full && !((alu_rd != 5'd0) && pending_c[alu_rd]);

  assign alu_wr = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign push   = ld_valid && ld_ready && (ld_rd != 5'd0);
  // A zero-rd ALU result takes no port slot, so the head may still drain.
  assign pop    = !alu_wr && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    we3_d    = 1'b0;

    if (alu_wr) begin
      a3_d  = alu_rd;
      wd3_d = alu_data;
      we3_d = 1'b1;
    end else if (pop) begin
      a3_d  = rd_mem_q[rd_ptr_q];
      wd3_d = data_mem_q[rd_ptr_q];
      we3_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a3_q     <= '0;
      wd3_q    <= '0;
      we3_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      we3_q    <= we3_d;
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= ld_rd;
      data_mem_q[wr_ptr_q] <= ld_data;
    end
  end

  assign A3      = a3_q;
  assign WD3     = wd3_q;
  assign WE3     = we3_q;
  assign pending = pending_c;
  assign busy    = (count_q != '0) || we3_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations (DEPTH = 4).
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] pending;
  logic        busy;

  int tests;
  int fails;

  rf_write_arbiter #(.DEPTH(4), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .A3        (A3),
    .WD3       (WD3),
    .WE3       (WE3),
    .pending   (pending),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen_we;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    #1;
    chk("rst_we3", WE3, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_busy", busy, 0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("idle_we3", WE3, 0);

    // ALU write rd=5 data=6
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h6;
    #1 chk("alu_ready_free", alu_ready, 1);
    cyc();
    alu_valid = 1'b0;
    chk("alu_we3", WE3, 1);
    chk("alu_a3", A3, 5);
    chk("alu_wd3", WD3, 32'h6);
    cyc();
    chk("alu_we3_off", WE3, 0);
    chk("alu_a3_hold", A3, 5);
    chk("alu_wd3_hold", WD3, 32'h6);

    // Loads 9, 11, 12 on consecutive edges
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h90;
    #1 chk("ld_ready_empty", ld_ready, 1);
    cyc();
    chk("ld9_pending", pending, 32'h1 << 9);
    chk("ld9_we3_not_yet", WE3, 0);
    ld_rd = 5'd11; ld_data = 32'hB0;
    cyc();
    chk("ld9_we3", WE3, 1);
    chk("ld9_a3", A3, 9);
    chk("ld9_wd3", WD3, 32'h90);
    chk("ld11_pending", pending, 32'h1 << 11);
    ld_rd = 5'd12; ld_data = 32'hC0;
    cyc();
    ld_valid = 1'b0;
    chk("ld11_a3", A3, 11);
    chk("ld11_wd3", WD3, 32'hB0);
    chk("ld12_pending", pending, 32'h1 << 12);
    cyc();
    chk("ld12_we3", WE3, 1);
    chk("ld12_a3", A3, 12);
    chk("ld_pending_clear", pending, 0);
    cyc();
    chk("ld_we3_off", WE3, 0);
    chk("ld_busy_off", busy, 0);

    // Fill the FIFO while the ALU owns the port every cycle
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'(32'h100 + i);
      ld_valid  = 1'b1; ld_rd  = 5'(1 + i);  ld_data  = 32'(32'h200 + i);
      #1;
      chk("fill_alu_ready", alu_ready, 1);
      chk("fill_ld_ready", ld_ready, 1);
      cyc();
      chk("fill_alu_a3", A3, 20 + i);
      chk("fill_alu_wd3", WD3, 32'h100 + i);
    end
    ld_valid = 1'b0;
    alu_rd = 5'd24; alu_data = 32'h124;
    #1;
    chk("full_ld_ready", ld_ready, 0);
    chk("full_alu_ready", alu_ready, 0);
    chk("full_pending", pending, 32'h1E);
    chk("full_busy", busy, 1);
    cyc();
    chk("full_pop_we3", WE3, 1);
    chk("full_pop_a3", A3, 1);
    chk("full_pop_wd3", WD3, 32'h200);
    chk("after_pop_ld_ready", ld_ready, 1);
    chk("after_pop_alu_ready", alu_ready, 1);
    chk("after_pop_pending", pending, 32'h1C);
    alu_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("drain_a3", A3, 1 + i);
      chk("drain_wd3", WD3, 32'h200 + i);
    end
    chk("drain_pending", pending, 0);
    cyc();
    chk("drain_we3_off", WE3, 0);

    // WAW: load to rd 6 queued, then ALU to rd 6
    ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66;
    cyc();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hA;
    #1 chk("waw_alu_stall", alu_ready, 0);
    cyc();
    chk("waw_load_first_a3", A3, 6);
    chk("waw_load_first_wd3", WD3, 32'h66);
    chk("waw_alu_release", alu_ready, 1);
    cyc();
    alu_valid = 1'b0;
    chk("waw_alu_second_we3", WE3, 1);
    chk("waw_alu_second_wd3", WD3, 32'hA);
    cyc();

    // Writes to x0 from both channels
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'hBEEF;
    #1;
    chk("x0_alu_ready", alu_ready, 1);
    chk("x0_ld_ready", ld_ready, 1);
    cyc();
    alu_valid = 1'b0; ld_valid = 1'b0;
    chk("x0_we3", WE3, 0);
    chk("x0_pending", pending, 0);
    chk("x0_busy", busy, 0);
    cyc();
    chk("x0_we3_later", WE3, 0);

    // Reset mid-drain with three loads queued
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(25 + i); alu_data = 32'(32'h300 + i);
      ld_valid  = 1'b1; ld_rd  = 5'(13 + i); ld_data  = 32'(32'h400 + i);
      cyc();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    chk("mid_pending", pending, 32'h0000E000);
    rst = 1'b0;
    #1;
    chk("mid_rst_we3", WE3, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_a3", A3, 0);
    chk("mid_rst_wd3", WD3, 0);
    chk("mid_rst_ld_ready", ld_ready, 1);
    chk("mid_rst_alu_ready", alu_ready, 1);
    cyc();
    rst = 1'b1;
    seen_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (WE3) seen_we = 1'b1;
    end
    chk("no_ghost_write", seen_we, 0);
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
